fp_divider_core: RTL



---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp_round_pack.sv | 38 +++
 rtl/fp_divider_core.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths, exponent bias,
// canonical special encodings, divider FSM states and operand classifiers.
package fpu_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

  function automatic logic is_nan(input logic [31:0] w);
    return (&w[30:23]) && (|w[22:0]);
  endfunction

  function automatic logic is_denorm(input logic [31:0] w);
    return (w[30:23] == 8'd0) && (|w[22:0]);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalize / round-to-nearest-even / pack for the divider.
//   sign    : result sign
//   exp_in  : biased exponent before normalization (10-bit signed)
//   quo     : 26-bit raw quotient, quo[25] set when no shift is needed
//   rem_nz  : final remainder non-zero (sticky source)
//   word    : packed single-precision result, overflow -> inf, underflow -> 0
module fp_round_pack
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [25:0]       quo,
  input  logic              rem_nz,
  output logic [31:0]       word
);

  logic [24:0]       qn;
  logic signed [9:0] e_n, e_r;
  logic [22:0]       frac;
  logic              guard, sticky, inc;
  logic [23:0]       sum;

  always_comb begin
    qn     = quo[25] ? quo[24:0] : {quo[23:0], 1'b0};
    e_n    = quo[25] ? exp_in : exp_in - 10'sd1;
    frac   = qn[24:2];
    guard  = qn[1];
    sticky = rem_nz | qn[0];
    inc    = guard & (sticky | frac[0]);
    sum    = {1'b0, frac} + {23'd0, inc};
    // carry-out leaves sum[22:0] at zero, only the exponent moves
    e_r    = sum[23] ? e_n + 10'sd1 : e_n;
    if (e_r >= 10'sd255)   word = {sign, POS_INF[30:0]};
    else if (e_r <= 10'sd0) word = {sign, 31'd0};
    else                    word = {sign, e_r[7:0], sum[22:0]};
  end

endmodule

// File: rtl/fp_divider_core.sv
// Sequential single-precision divider with start/busy/done handshake.
//   start, float_num1, float_num2 : request and operands (sampled in IDLE)
//   exc_sel, exc_out             : exception handler select / special word
//   busy                         : high outside IDLE
//   done                         : one-cycle result-valid pulse
//   result                       : quotient, held until the next accepted start
// Special cases (exc_sel=0, NaN, denormal flush) finish one cycle after
// start; normal operands run 26 restoring iterations, one NORM cycle, DONE.
module fp_divider_core
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_W,
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int MANT_WIDTH = FP_MANT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] float_num1,
  input  logic [DATA_WIDTH-1:0] float_num2,
  input  logic                  exc_sel,
  input  logic [DATA_WIDTH-1:0] exc_out,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int ITERS = MANT_WIDTH + 3;

  state_t                state;
  logic [4:0]            cnt;
  logic                  sign_r;
  logic signed [9:0]     exp_r;
  logic [MANT_WIDTH:0]   dvsr;
  logic [MANT_WIDTH+1:0] rem;
  logic [ITERS-1:0]      quo;

  logic                  s_in;
  logic [EXP_WIDTH-1:0]  e1, e2;
  logic                  special;
  logic                  ge;
  logic [MANT_WIDTH:0]   diff;
  logic [31:0]           packed_w;

  always_comb begin
    s_in    = float_num1[DATA_WIDTH-1] ^ float_num2[DATA_WIDTH-1];
    e1      = float_num1[DATA_WIDTH-2 -: EXP_WIDTH];
    e2      = float_num2[DATA_WIDTH-2 -: EXP_WIDTH];
    special = is_nan(float_num1) || is_nan(float_num2) ||
              is_denorm(float_num1) || is_denorm(float_num2);
    ge      = rem >= {1'b0, dvsr};
    // when ge holds the difference is below the divisor, so the low bits suffice
    diff    = rem[MANT_WIDTH:0] - dvsr;
  end

  fp_round_pack u_round_pack (
    .sign   (sign_r),
    .exp_in (exp_r),
    .quo    (quo),
    .rem_nz (|rem),
    .word   (packed_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sign_r <= 1'b0;
      exp_r  <= '0;
      dvsr   <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (!exc_sel || special) begin
              state <= DONE;
              done  <= 1'b1;
              if (!exc_sel)                result <= exc_out;
              else if (is_nan(float_num1) || is_nan(float_num2))
                                           result <= QNAN;
              else if (is_denorm(float_num1)) result <= {s_in, 31'd0};
              else                         result <= {s_in, POS_INF[30:0]};
            end else begin
              state  <= CALC;
              cnt    <= '0;
              quo    <= '0;
              sign_r <= s_in;
              exp_r  <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'(FP_BIAS);
              rem    <= {2'b01, float_num1[MANT_WIDTH-1:0]};
              dvsr   <= {1'b1, float_num2[MANT_WIDTH-1:0]};
            end
          end
        end
        CALC: begin
          rem <= ge ? {diff, 1'b0} : {rem[MANT_WIDTH:0], 1'b0};
          quo <= {quo[ITERS-2:0], ge};
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1)) state <= NORM;
        end
        NORM: begin
          result <= packed_w;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
